// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends preamble/SFD, pads to the minimum length,
// appends the CRC-32 FCS and enforces an inter-frame gap.
module eth_tx_framer #(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_CYCLES  = 12,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  localparam logic [11:0] MIN12 = 12'(MIN_FRAME);
  localparam logic [15:0] IFG16 = 16'(IFG_CYCLES);

  state_t      state, state_n;
  logic [7:0]  tdata_q;
  logic        tvalid_q, tlast_q;
  logic [31:0] crc, fcs;
  logic [10:0] byte_cnt;
  logic [11:0] cnt_plus1;
  logic [2:0]  pre_cnt, fcs_idx;
  logic [15:0] ifg_cnt, frame_cnt;
  logic        slot_free;

  logic        load, ld_last, crc_en, cnt_en, pre_inc, fcs_inc, frame_done, ifg_inc;
  logic [7:0]  ld_data;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
    return r;
  endfunction

  assign slot_free = !tvalid_q || m_axis_tready;
  assign fcs       = ~crc;
  assign cnt_plus1 = {1'b0, byte_cnt} + 12'd1;

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    ld_data    = 8'h00;
    ld_last    = 1'b0;
    crc_en     = 1'b0;
    cnt_en     = 1'b0;
    pre_inc    = 1'b0;
    fcs_inc    = 1'b0;
    frame_done = 1'b0;
    ifg_inc    = 1'b0;
    case (state)
      S_IDLE: if (s_axis_tvalid) begin
        if (PREAMBLE_EN) begin
          load    = 1'b1;
          ld_data = 8'h55;
          pre_inc = 1'b1;
          state_n = S_PREAMBLE;
        end else begin
          state_n = S_DATA;
        end
      end
      S_PREAMBLE: if (slot_free) begin
        load = 1'b1;
        if (pre_cnt < 3'd7) begin
          ld_data = 8'h55;
          pre_inc = 1'b1;
        end else begin
          ld_data = 8'hD5;
          state_n = S_DATA;
        end
      end
      S_DATA: if (slot_free && s_axis_tvalid) begin
        load    = 1'b1;
        ld_data = s_axis_tdata;
        crc_en  = 1'b1;
        cnt_en  = 1'b1;
        if (s_axis_tlast) state_n = (cnt_plus1 < MIN12) ? S_PAD : S_FCS;
      end
      S_PAD: if (slot_free) begin
        load   = 1'b1;
        crc_en = 1'b1;
        cnt_en = 1'b1;
        if (cnt_plus1 >= MIN12) state_n = S_FCS;
      end
      S_FCS: if (slot_free) begin
        // fcs_idx==4 means the tlast byte sits in the slot; free slot => accepted
        if (fcs_idx == 3'd4) begin
          frame_done = 1'b1;
          state_n    = (IFG_CYCLES > 1) ? S_IFG : S_IDLE;
        end else begin
          load    = 1'b1;
          ld_data = fcs[{fcs_idx[1:0], 3'b000} +: 8];
          ld_last = (fcs_idx == 3'd3);
          fcs_inc = 1'b1;
        end
      end
      S_IFG: begin
        // IDLE contributes the last gap cycle before the next preamble load
        if (ifg_cnt + 16'd2 >= IFG16) state_n = S_IDLE;
        else                          ifg_inc = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      crc       <= 32'hFFFFFFFF;
      byte_cnt  <= '0;
      pre_cnt   <= '0;
      fcs_idx   <= '0;
      ifg_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      if (slot_free) begin
        tvalid_q <= load;
        tlast_q  <= load && ld_last;
        if (load) tdata_q <= ld_data;
      end
      if (state == S_IDLE) crc <= 32'hFFFFFFFF;
      else if (crc_en)     crc <= crc_byte(crc, ld_data);
      if (state == S_IDLE)                   byte_cnt <= '0;
      else if (cnt_en && byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
      if (state == S_IDLE) pre_cnt <= {2'b00, pre_inc};
      else if (pre_inc)    pre_cnt <= pre_cnt + 3'd1;
      if (state == S_IDLE) fcs_idx <= '0;
      else if (fcs_inc)    fcs_idx <= fcs_idx + 3'd1;
      if (state != S_IFG)  ifg_cnt <= '0;
      else if (ifg_inc)    ifg_cnt <= ifg_cnt + 16'd1;
      if (frame_done)      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign s_axis_tready = (state == S_DATA) && slot_free;
  assign busy          = (state != S_IDLE);
  assign frames_sent   = frame_cnt;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: table of frame scenarios checked against
// a byte-level reference stream, plus hand sequences for gap and reset cases.
module tb_eth_tx_framer;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00, m_tdata;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        m_tvalid, m_tready = 1'b1, m_tlast, busy;
  logic [15:0] fs;

  logic [7:0]  s0_tdata = 8'h00, m0_tdata;
  logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
  logic        m0_tvalid, m0_tready = 1'b1, m0_tlast, busy0;
  logic [15:0] fs0;

  int checks = 0, errors = 0, cyc = 0, stab_err = 0, exp_fs = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] cap_d[$], c0_d[$], exp_q[$];
  logic       cap_l[$], c0_l[$], exp_l[$];
  int         cap_t[$], c0_t[$];
  logic       hold_pend = 1'b0, hold_l = 1'b0;
  logic [7:0] hold_d = 8'h00;

  typedef struct {
    int len; bit rnd; int gap_at; int gap_len; int exp_total; int exp_span;
  } vec_t;
  vec_t tbl[7];

  eth_tx_framer #(.MIN_FRAME(60), .IFG_CYCLES(12), .PREAMBLE_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .busy(busy), .frames_sent(fs));

  eth_tx_framer #(.MIN_FRAME(0), .IFG_CYCLES(12), .PREAMBLE_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready), .s_axis_tlast(s0_tlast),
    .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready), .m_axis_tlast(m0_tlast),
    .busy(busy0), .frames_sent(fs0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Capture accepted bytes and watch that a stalled slot holds its contents
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      cap_d.push_back(m_tdata); cap_l.push_back(m_tlast); cap_t.push_back(cyc);
    end
    if (!rst && m0_tvalid && m0_tready) begin
      c0_d.push_back(m0_tdata); c0_l.push_back(m0_tlast); c0_t.push_back(cyc);
    end
    if (!rst && hold_pend && (!m_tvalid || m_tdata !== hold_d || m_tlast !== hold_l))
      stab_err <= stab_err + 1;
    hold_pend <= !rst && m_tvalid && !m_tready;
    hold_d    <= m_tdata;
    hold_l    <= m_tlast;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int len, input int i);
    return 8'((i * 13 + len * 3 + 1) & 255);
  endfunction

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic add_exp(input int len, input int min_f);
    logic [31:0] c;
    logic [7:0]  b;
    int n;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin exp_q.push_back(k == 7 ? 8'hD5 : 8'h55); exp_l.push_back(1'b0); end
    n = (len < min_f) ? min_f : len;
    for (int i = 0; i < n; i++) begin
      b = (i < len) ? pat(len, i) : 8'h00;
      c = crc8(c, b);
      exp_q.push_back(b); exp_l.push_back(1'b0);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin exp_q.push_back(c[8*k +: 8]); exp_l.push_back(k == 3); end
  endtask

  task automatic drive_frame(input bit sel, input int len, input int gap_at, input int gap_len);
    int budget;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        s_tvalid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      if (sel) begin s0_tdata = 8'(8'h31 + i); s0_tvalid = 1'b1; s0_tlast = (i == len - 1); end
      else     begin s_tdata = pat(len, i);    s_tvalid = 1'b1;  s_tlast = (i == len - 1);  end
      budget = 0;
      forever begin
        @(negedge clk);
        if ((sel ? s0_tready : s_tready) === 1'b1) begin @(posedge clk); #1; break; end
        budget++;
        if (budget > 500) begin
          check("drive handshake timeout", budget, 0);
          s_tvalid = 1'b0; s0_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((sel ? busy0 : busy) === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("busy release timeout", n >= 3000, 0);
  endtask

  task automatic compare(input string nm, input int total, input int start, input int span);
    int bad_d, bad_l, n;
    bad_d = 0; bad_l = 0;
    check({nm, " byte count"}, cap_d.size(), total);
    n = (cap_d.size() < exp_q.size()) ? cap_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (cap_d[i] !== exp_q[i]) bad_d++;
      if (cap_l[i] !== exp_l[i]) bad_l++;
    end
    check({nm, " data mismatches"}, bad_d, 0);
    check({nm, " tlast mismatches"}, bad_l, 0);
    if (start >= 0 && n > 0) check({nm, " first byte latency"}, cap_t[0] - start, 1);
    if (span >= 0 && n > 0) check({nm, " span cycles"}, cap_t[n-1] - cap_t[0], span);
    cap_d.delete(); cap_l.delete(); cap_t.delete(); exp_q.delete(); exp_l.delete();
  endtask

  initial begin
    logic [7:0] exp9 [13];
    int start, bad, idle_gap;
    exp9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    tbl[0] = '{14, 1'b0, -1, 0, 72, 71};
    tbl[1] = '{60, 1'b0, -1, 0, 72, 71};
    tbl[2] = '{64, 1'b1, -1, 0, 76, -1};
    tbl[3] = '{64, 1'b0, -1, 0, 76, 75};
    tbl[4] = '{60, 1'b0, 20, 5, 72, 76};
    tbl[5] = '{59, 1'b0, -1, 0, 72, 71};
    tbl[6] = '{61, 1'b0, -1, 0, 73, 72};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset m_tvalid", m_tvalid, 0);
    check("reset m_tlast", m_tlast, 0);
    check("reset m_tdata", m_tdata, 0);
    check("reset s_tready", s_tready, 0);
    check("reset busy", busy, 0);
    check("reset frames_sent", fs, 0);

    // Check value: no preamble, no padding, standard CRC-32 of "123456789"
    drive_frame(1'b1, 9, -1, 0);
    wait_idle(1'b1);
    check("ascii byte count", c0_d.size(), 13);
    bad = 0;
    for (int i = 0; i < c0_d.size() && i < 13; i++)
      if (c0_d[i] !== exp9[i] || c0_l[i] !== (i == 12)) bad++;
    check("ascii byte/tlast mismatches", bad, 0);
    if (c0_t.size() == 13) check("ascii span cycles", c0_t[12] - c0_t[0], 12);
    check("ascii frames_sent", fs0, 1);

    foreach (tbl[i]) begin
      rnd_ready = tbl[i].rnd;
      add_exp(tbl[i].len, 60);
      start = cyc;
      drive_frame(1'b0, tbl[i].len, tbl[i].gap_at, tbl[i].gap_len);
      wait_idle(1'b0);
      rnd_ready = 1'b0;
      compare($sformatf("vec%0d len%0d", i, tbl[i].len), tbl[i].exp_total,
              tbl[i].rnd ? -1 : start, tbl[i].exp_span);
      exp_fs++;
      check($sformatf("vec%0d frames_sent", i), fs, exp_fs);
    end
    check("slot hold while stalled", stab_err, 0);

    // Back-to-back: second frame queued while the first is still draining
    add_exp(60, 60);
    add_exp(100, 60);
    start = cyc;
    drive_frame(1'b0, 60, -1, 0);
    drive_frame(1'b0, 100, -1, 0);
    wait_idle(1'b0);
    idle_gap = (cap_t.size() > 72) ? cap_t[72] - cap_t[71] - 1 : -1;
    check("b2b idle cycles", idle_gap, 12);
    compare("b2b", 184, start, -1);
    exp_fs += 2;
    check("b2b frames_sent", fs, exp_fs);

    // Reset while padding a short frame, then a clean frame
    drive_frame(1'b0, 14, -1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy during pad", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pad reset m_tvalid", m_tvalid, 0);
    check("pad reset m_tlast", m_tlast, 0);
    check("pad reset m_tdata", m_tdata, 0);
    check("pad reset s_tready", s_tready, 0);
    check("pad reset busy", busy, 0);
    check("pad reset frames_sent", fs, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cap_d.delete(); cap_l.delete(); cap_t.delete();
    exp_fs = 0;
    add_exp(60, 60);
    start = cyc;
    drive_frame(1'b0, 60, -1, 0);
    wait_idle(1'b0);
    compare("post-reset", 72, start, 71);
    exp_fs++;
    check("post-reset frames_sent", fs, exp_fs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
